cpu7_ifu_ibuf: RTL

Instruction buffer between the fetch datapath and decode. It queues fetched `{pc, inst, excp}` triples in a small circular FIFO and presents them one at a time to the decode/immediate-generation stage over a valid/ready handshake. A pipeline flush from the execute stage empties it. Fetch runs ahead of decode stalls, so decode never sees a bubble while the buffer holds entries.

---
 rtl/cpu7_ifu_ibuf_pkg.sv | 24 ++
 rtl/cpu7_ifu_ibuf_mem.sv | 30 +++
 rtl/cpu7_ifu_ibuf.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu7_ifu_ibuf_pkg.sv
// Shared types and entry field layout for the IFU instruction buffer.
// Entry layout macros live here so every ibuf file sees the same packing.
`ifndef GRLEN
`define GRLEN 32
`endif
`ifndef LSOC1K_IBUF_ENTRY_BIT
`define LSOC1K_IBUF_ENTRY_BIT (32 + `GRLEN + 1)
`define LSOC1K_IBUF_INST_LSB 0
`define LSOC1K_IBUF_PC_LSB 32
`define LSOC1K_IBUF_EXCP_BIT (32 + `GRLEN)
`endif

package cpu7_ifu_ibuf_pkg;

  localparam int GRLEN   = `GRLEN;
  localparam int ENTRY_W = `LSOC1K_IBUF_ENTRY_BIT;

  typedef struct packed {
    logic             excp;
    logic [GRLEN-1:0] pc;
    logic [31:0]      inst;
  } ibuf_entry_t;

endpackage

// File: rtl/cpu7_ifu_ibuf_mem.sv
// Instruction buffer storage: DEPTH x entry registers,
// one write port and one combinational read port.
module cpu7_ifu_ibuf_mem
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  ibuf_entry_t       wdata,
  input  logic [AW-1:0]     raddr,
  output ibuf_entry_t       rdata
);

  ibuf_entry_t mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu7_ifu_ibuf.sv
// Fetch-to-decode instruction buffer (circular FIFO with flush).
// Define CPU7_IFU_IBUF_BYPASS_EN for a zero-latency path when empty.
module cpu7_ifu_ibuf
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fdp_ibuf_vld,
  input  logic [31:0]       fdp_ibuf_inst,
  input  logic [GRLEN-1:0]  fdp_ibuf_pc,
  input  logic              fdp_ibuf_excp,
  output logic              ibuf_fdp_rdy,
  input  logic              exu_ifu_flush,
  output logic              ibuf_dec_vld,
  output logic [31:0]       ibuf_dec_inst,
  output logic [GRLEN-1:0]  ibuf_dec_pc,
  output logic              ibuf_dec_excp,
  input  logic              dec_ibuf_rdy,
  output logic [PTR_W:0]    ibuf_cnt
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   cnt;
  logic             empty, full;
  logic             push, pop;
  logic             mem_we, mem_pop;
  ibuf_entry_t      in_ent, head_ent, out_ent;

  assign empty  = (cnt == '0);
  assign full   = (cnt == FULL_CNT);
  assign in_ent = '{excp: fdp_ibuf_excp, pc: fdp_ibuf_pc,
                    inst: fdp_ibuf_inst};

  assign ibuf_fdp_rdy = !full && !exu_ifu_flush;
  assign push = fdp_ibuf_vld && ibuf_fdp_rdy;
  assign pop  = ibuf_dec_vld && dec_ibuf_rdy;

`ifdef CPU7_IFU_IBUF_BYPASS_EN
  logic byp;
  // Empty and not flushing: fetch data goes straight to decode.
  assign byp          = empty && !exu_ifu_flush;
  assign ibuf_dec_vld = byp ? fdp_ibuf_vld : (!empty && !exu_ifu_flush);
  assign out_ent      = byp ? in_ent : head_ent;
  assign mem_we       = push && !(byp && dec_ibuf_rdy);
  assign mem_pop      = pop && !empty;
`else
  assign ibuf_dec_vld = !empty && !exu_ifu_flush;
  assign out_ent      = head_ent;
  assign mem_we       = push;
  assign mem_pop      = pop;
`endif

  assign ibuf_dec_inst = out_ent.inst;
  assign ibuf_dec_pc   = out_ent.pc;
  assign ibuf_dec_excp = out_ent.excp;
  assign ibuf_cnt      = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (exu_ifu_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (mem_we)  wr_ptr <= wr_ptr + PTR_ONE;
      if (mem_pop) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({mem_we, mem_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  cpu7_ifu_ibuf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (in_ent),
    .raddr (rd_ptr),
    .rdata (head_ent)
  );

endmodule
